// File: rtl/npu_pkg.sv
// npu_pkg: shared opcodes and FSM state encoding for the NPU MAC engine
//   OP_DOT       plain int8 dot product plus bias
//   OP_DOT_RELU  dot product plus bias, negative results clamped to zero
//   state_t      engine FSM states
package npu_pkg;
  localparam logic [7:0] OP_DOT      = 8'h01;
  localparam logic [7:0] OP_DOT_RELU = 8'h02;
  typedef enum logic [2:0] {S_IDLE, S_FETCH_IN, S_FETCH_W, S_MAC, S_FINISH} state_t;
endpackage

// File: rtl/npu_mac4.sv
// npu_mac4: combinational 4-lane signed int8 dot product
//   a, b  in   32  packed int8 lanes, byte i of a pairs with byte i of b
//   y     out  18  signed sum of the four 16-bit lane products
module npu_mac4 (
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic signed [17:0] y
);
  logic signed [15:0] p [4];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign p[i] = 16'($signed(a[8*i +: 8])) * 16'($signed(b[8*i +: 8]));
  end
  assign y = 18'(p[0]) + 18'(p[1]) + 18'(p[2]) + 18'(p[3]);
endmodule

// File: rtl/npu_mac_engine.sv
// npu_mac_engine: int8 dot-product accelerator behind the accel start/done handshake
//   clk, rst_n        clock and synchronous active-low reset
//   accel_cmd         [31:24] opcode, [23:0] input vector byte address
//   accel_start       command strobe, accepted only when idle and not in the done cycle
//   cfg_weights_addr  weight vector byte address
//   cfg_length        words per vector
//   cfg_bias          initial accumulator value
//   mem_addr, mem_re  read request, held stable until mem_ready
//   mem_data_in       read data, taken when mem_re && mem_ready
//   mem_ready         read acknowledge
//   accel_busy        high from the cycle after accept through the done cycle
//   accel_done        one-cycle completion pulse
//   accel_result      final (optionally ReLU'd) accumulator
//   accel_error       last command carried an unknown opcode
module npu_mac_engine
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] accel_cmd,
  input  logic                  accel_start,
  input  logic [ADDR_WIDTH-1:0] cfg_weights_addr,
  input  logic [LEN_W-1:0]      cfg_length,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ready,
  output logic                  accel_busy,
  output logic                  accel_done,
  output logic [DATA_WIDTH-1:0] accel_result,
  output logic                  accel_error
);
  state_t                state;
  logic [7:0]            op;
  logic [ADDR_WIDTH-1:0] in_addr, w_addr;
  logic [LEN_W-1:0]      len, idx, idx_n;
  logic [DATA_WIDTH-1:0] acc, in_word, w_word;
  logic signed [17:0]    dot;
  logic                  cmd_ok, accept, bad;

  npu_mac4 u_mac4 (.a(in_word), .b(w_word), .y(dot));

  assign idx_n  = idx + 1'b1;
  assign cmd_ok = accel_cmd[31:24] == OP_DOT || accel_cmd[31:24] == OP_DOT_RELU;
  assign accept = accel_start && !accel_done;
  assign bad    = op != OP_DOT && op != OP_DOT_RELU;

  // mem_re/mem_addr are registered and set up on the edge entering each fetch state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= '0;
      in_addr      <= '0;
      w_addr       <= '0;
      len          <= '0;
      idx          <= '0;
      acc          <= '0;
      in_word      <= '0;
      w_word       <= '0;
      mem_addr     <= '0;
      mem_re       <= 1'b0;
      accel_busy   <= 1'b0;
      accel_done   <= 1'b0;
      accel_result <= '0;
      accel_error  <= 1'b0;
    end else begin
      accel_done <= 1'b0;
      case (state)
        S_IDLE: begin
          accel_busy <= accept;
          if (accept) begin
            op           <= accel_cmd[31:24];
            in_addr      <= ADDR_WIDTH'(accel_cmd[23:0]);
            w_addr       <= cfg_weights_addr;
            len          <= cfg_length;
            acc          <= cfg_bias;
            idx          <= '0;
            accel_error  <= 1'b0;
            accel_result <= '0;
            mem_addr     <= ADDR_WIDTH'(accel_cmd[23:0]);
            mem_re       <= cmd_ok && cfg_length != '0;
            state        <= (cmd_ok && cfg_length != '0) ? S_FETCH_IN : S_FINISH;
          end
        end
        S_FETCH_IN: if (mem_ready) begin
          in_word  <= mem_data_in;
          mem_addr <= w_addr + ADDR_WIDTH'({idx, 2'b00});
          state    <= S_FETCH_W;
        end
        S_FETCH_W: if (mem_ready) begin
          w_word <= mem_data_in;
          mem_re <= 1'b0;
          state  <= S_MAC;
        end
        S_MAC: begin
          acc      <= acc + DATA_WIDTH'(dot);
          idx      <= idx_n;
          mem_addr <= in_addr + ADDR_WIDTH'({idx_n, 2'b00});
          mem_re   <= idx_n < len;
          state    <= idx_n < len ? S_FETCH_IN : S_FINISH;
        end
        S_FINISH: begin
          accel_result <= (bad || (op == OP_DOT_RELU && acc[DATA_WIDTH-1])) ? '0 : acc;
          accel_error  <= bad;
          accel_done   <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_mac_engine.sv
// tb_npu_mac_engine: directed and randomized checks of npu_mac_engine against a reference model
module tb_npu_mac_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] accel_cmd = '0;
  logic        accel_start = 1'b0;
  logic [31:0] cfg_weights_addr = '0;
  logic [15:0] cfg_length = '0;
  logic [31:0] cfg_bias = '0;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic        accel_busy, accel_done, accel_error;
  logic [31:0] accel_result;

  npu_mac_engine dut (
    .clk(clk), .rst_n(rst_n), .accel_cmd(accel_cmd), .accel_start(accel_start),
    .cfg_weights_addr(cfg_weights_addr), .cfg_length(cfg_length), .cfg_bias(cfg_bias),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .accel_busy(accel_busy), .accel_done(accel_done), .accel_result(accel_result),
    .accel_error(accel_error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int          stall = 0;
  int          cnt = 0;
  logic [31:0] rd_log [$];
  bit          unstable = 0, re_seen = 0, wait_v = 0;
  logic [31:0] wait_a = '0;
  int          done_cnt = 0;
  int          pass = 0, total = 0;

  assign mem_data_in = mem[mem_addr[9:2]];
  assign mem_ready   = cnt >= stall;

  always @(posedge clk) begin
    if (mem_re && mem_ready) rd_log.push_back(mem_addr);
    if (wait_v && (mem_re !== 1'b1 || mem_addr !== wait_a)) unstable = 1;
    wait_v = mem_re && !mem_ready;
    wait_a = mem_addr;
    if (mem_re) re_seen = 1;
    if (accel_done) done_cnt++;
    cnt <= (!mem_re || mem_ready) ? 0 : cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] ia, input logic [31:0] wa,
                                        input int len, input logic [31:0] bias);
    int s = int'(bias);
    logic [31:0] iw, ww, a, b;
    if (op != 8'h01 && op != 8'h02) return 0;
    for (int k = 0; k < len; k++) begin
      a  = ia + 32'(4 * k);
      b  = wa + 32'(4 * k);
      iw = mem[a[9:2]];
      ww = mem[b[9:2]];
      for (int l = 0; l < 4; l++)
        s += int'($signed(iw[8*l +: 8])) * int'($signed(ww[8*l +: 8]));
    end
    if (op == 8'h02 && s < 0) s = 0;
    return s;
  endfunction

  task automatic run(input string tag, input logic [7:0] op, input logic [23:0] ia, input logic [31:0] wa,
                     input int len, input logic [31:0] bias, input bit noisy,
                     output logic [31:0] res, output logic err, output int lat);
    int limit = 100 + len * 3 * (stall + 2);
    bit busy_ok = 1;
    @(negedge clk);
    accel_cmd = {op, ia}; cfg_weights_addr = wa; cfg_length = 16'(len); cfg_bias = bias; accel_start = 1'b1;
    rd_log.delete(); unstable = 0; re_seen = 0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noisy) begin
        accel_cmd = $urandom; cfg_weights_addr = $urandom; cfg_length = 16'($urandom); cfg_bias = $urandom;
      end else accel_start = 1'b0;
      if (accel_busy !== 1'b1) busy_ok = 0;
    end while (accel_done !== 1'b1 && lat < limit);
    chk({tag, "_timeout"}, 32'(accel_done), 32'd1);
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    res = accel_result;
    err = accel_error;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(accel_done), 32'd0);
    chk({tag, "_busy_after"}, 32'(accel_busy), 32'd0);
    accel_start = 1'b0;
  endtask

  logic [31:0] res;
  logic        err;
  int          lat, len, d0;
  logic [7:0]  op;
  logic [23:0] ia;
  logic [31:0] wa, bias;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_result", accel_result, 32'h0);
    chk("rst_error", 32'(accel_error), 32'd0);
    chk("rst_busy", 32'(accel_busy), 32'd0);
    chk("rst_done", 32'(accel_done), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    mem[64] = 32'h01020304; mem[128] = 32'h01010101;
    run("t1", 8'h01, 24'h100, 32'h200, 1, 32'd10, 0, res, err, lat);
    chk("t1_result", res, 32'h14);
    chk("t1_error", 32'(err), 32'd0);
    chk("t1_latency", 32'(lat), 32'd5);

    mem[64] = 32'hFFFFFFFF; mem[128] = 32'h7F7F7F7F;
    run("t2r", 8'h02, 24'h100, 32'h200, 1, 32'd0, 0, res, err, lat);
    chk("t2_relu", res, 32'h0);
    run("t2d", 8'h01, 24'h100, 32'h200, 1, 32'd0, 0, res, err, lat);
    chk("t2_dot", res, 32'hFFFFFE04);

    run("t3", 8'h01, 24'h100, 32'h200, 0, -32'sd7, 0, res, err, lat);
    chk("t3_result", res, 32'hFFFFFFF9);
    chk("t3_latency", 32'(lat), 32'd2);
    chk("t3_no_re", 32'(re_seen), 32'd0);

    run("t4", 8'h7E, 24'h100, 32'h200, 4, 32'd99, 0, res, err, lat);
    chk("t4_result", res, 32'h0);
    chk("t4_error", 32'(err), 32'd1);
    chk("t4_latency", 32'(lat), 32'd2);
    chk("t4_no_re", 32'(re_seen), 32'd0);
    run("t4b", 8'h01, 24'h100, 32'h200, 1, 32'd0, 0, res, err, lat);
    chk("t4b_error", 32'(err), 32'd0);
    chk("t4b_result", res, model(8'h01, 32'h100, 32'h200, 1, 32'd0));

    stall = 3;
    run("t5", 8'h01, 24'h040, 32'h300, 3, 32'h1234, 0, res, err, lat);
    chk("t5_result", res, model(8'h01, 32'h040, 32'h300, 3, 32'h1234));
    chk("t5_stable", 32'(unstable), 32'd0);
    chk("t5_nreads", 32'(rd_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < rd_log.size(); k++)
      chk($sformatf("t5_read%0d", k), rd_log[k], (k % 2 == 0 ? 32'h040 : 32'h300) + 32'(4 * (k / 2)));

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      op    = $urandom_range(0, 1) ? 8'h01 : 8'h02;
      len   = $urandom_range(1, 5);
      ia    = 24'($urandom_range(0, 63) * 4);
      wa    = 32'h200 + 32'($urandom_range(0, 63) * 4);
      bias  = $urandom;
      stall = $urandom_range(0, 2);
      run($sformatf("rnd%0d", k), op, ia, wa, len, bias, k[0], res, err, lat);
      chk($sformatf("rnd%0d_result", k), res, model(op, 32'(ia), wa, len, bias));
      chk($sformatf("rnd%0d_error", k), 32'(err), 32'd0);
      chk($sformatf("rnd%0d_stable", k), 32'(unstable), 32'd0);
      if (stall == 0) chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(3 * len + 2));
    end

    stall = 3;
    @(negedge clk);
    accel_cmd = {8'h01, 24'h100}; cfg_weights_addr = 32'h200; cfg_length = 16'd3; cfg_bias = 32'd5;
    accel_start = 1'b1;
    rd_log.delete();
    @(negedge clk);
    accel_start = 1'b0;
    for (int t = 0; t < 50 && rd_log.size() < 1; t++) @(negedge clk);
    chk("t6_in_read", 32'(rd_log.size()), 32'd1);
    chk("t6_re_waiting", 32'(mem_re), 32'd1);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("t6_mem_re", 32'(mem_re), 32'd0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_busy", 32'(accel_busy), 32'd0);
    chk("t6_result", accel_result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_idle_re", 32'(mem_re), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
